// File: rtl/osc_phase_sequencer_if.sv
// Bus bundle for osc_phase_sequencer: tick strobe, voice config writes,
// shared-LUT request/response, mixed-sample output and status.
interface osc_phase_sequencer_if #(
  parameter int VOICE_W = 2,
  parameter int PHASE_W = 32
);
  // No back-pressure anywhere: sample_tick and cfg_we are single-cycle strobes
  // taken at the edge they are high; sample_valid is a one-cycle pulse that the
  // consumer must capture in that cycle; lut_value answers lut_index/lut_wave
  // combinationally within the same cycle.
  logic                sample_tick;
  logic                cfg_we;
  logic [VOICE_W-1:0]  cfg_voice;
  logic [PHASE_W-1:0]  cfg_incr;
  logic [1:0]          cfg_wave;
  logic                cfg_en;
  logic [15:0]         lut_index;
  logic [1:0]          lut_wave;
  logic [15:0]         lut_value;
  logic [15:0]         sample_out;
  logic                sample_valid;
  logic                busy;
  logic                overrun;
  logic [1:0]          dbg_state;

  modport master (
    output sample_tick, cfg_we, cfg_voice, cfg_incr, cfg_wave, cfg_en, lut_value,
    input  lut_index, lut_wave, sample_out, sample_valid, busy, overrun, dbg_state
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_voice, cfg_incr, cfg_wave, cfg_en, lut_value,
    output lut_index, lut_wave, sample_out, sample_valid, busy, overrun, dbg_state
  );
endinterface

// File: rtl/osc_phase_sequencer.sv
// Time-multiplexed multi-voice NCO: per sample tick, issues each voice's LUT
// index, sums the returned samples and emits one saturated mixed sample.
module osc_phase_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 2,
  parameter int PHASE_W    = 32
) (
  input logic                  clock,
  input logic                  reset,
  osc_phase_sequencer_if.slave bus
);
  localparam int AW = 16 + VOICE_W;
  localparam logic signed [AW-1:0] ACC_MAX = AW'(32767);
  localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                  r_state, w_state_next;
  logic [VOICE_W-1:0]      r_voice;
  logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
  logic [PHASE_W-1:0]      r_incr  [NUM_VOICES];
  logic [1:0]              r_wave  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_en;
  logic                    r_tag;
  logic signed [AW-1:0]    r_acc;
  logic [15:0]             r_lut_index;
  logic [1:0]              r_lut_wave;
  logic [15:0]             r_sample_out;
  logic                    r_sample_valid;
  logic                    r_overrun;

  logic                    w_issue;
  logic                    w_last;
  logic                    w_accum;
  logic signed [AW-1:0]    w_lut_ext;
  logic signed [AW-1:0]    w_acc_next;
  logic [15:0]             w_sat;

  assign w_issue    = (r_state == S_ISSUE);
  assign w_last     = (r_voice == VOICE_W'(NUM_VOICES - 1));
  // The LUT answers the index registered one cycle earlier, so accumulation
  // trails issue by one slot and finishes in DRAIN.
  assign w_accum    = (w_issue && (r_voice != '0)) || (r_state == S_DRAIN);
  assign w_lut_ext  = {{VOICE_W{bus.lut_value[15]}}, bus.lut_value};
  assign w_acc_next = r_acc + (r_tag ? w_lut_ext : '0);
  assign w_sat      = (w_acc_next > ACC_MAX) ? 16'h7FFF :
                      (w_acc_next < ACC_MIN) ? 16'h8001 : w_acc_next[15:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.sample_tick) w_state_next = S_ISSUE;
      S_ISSUE: if (w_last) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_voice        <= '0;
      r_tag          <= 1'b0;
      r_acc          <= '0;
      r_lut_index    <= '0;
      r_lut_wave     <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_en           <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= '0;
        r_incr[i]  <= '0;
        r_wave[i]  <= '0;
      end
    end else begin
      r_state        <= w_state_next;
      r_sample_valid <= 1'b0;
      if (bus.sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if ((r_state == S_IDLE) && bus.sample_tick) begin
        r_voice <= '0;
        r_acc   <= '0;
      end
      if (w_issue) begin
        r_lut_index <= r_phase[r_voice][PHASE_W-1 -: 16];
        r_lut_wave  <= r_wave[r_voice];
        r_tag       <= r_en[r_voice] && (r_wave[r_voice] != 2'd3);
        r_voice     <= r_voice + 1'b1;
      end
      if (w_accum) r_acc <= w_acc_next;
      if (r_state == S_DRAIN) begin
        r_sample_out   <= w_sat;
        r_sample_valid <= 1'b1;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (bus.cfg_we && (bus.cfg_voice == VOICE_W'(i))) begin
          r_incr[i] <= bus.cfg_incr;
          r_wave[i] <= bus.cfg_wave;
          r_en[i]   <= bus.cfg_en;
        end
        // Enabling a voice restarts it at phase 0, even over its own issue step.
        if (bus.cfg_we && (bus.cfg_voice == VOICE_W'(i)) && bus.cfg_en && !r_en[i])
          r_phase[i] <= '0;
        else if (w_issue && (r_voice == VOICE_W'(i)) && r_en[i])
          r_phase[i] <= r_phase[i] + r_incr[i];
      end
    end
  end

  assign bus.lut_index    = r_lut_index;
  assign bus.lut_wave     = r_lut_wave;
  assign bus.sample_out   = r_sample_out;
  assign bus.sample_valid = r_sample_valid;
  assign bus.busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign bus.overrun      = r_overrun;
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_osc_phase_sequencer.sv
// Self-checking bench for osc_phase_sequencer: LUT model, voice model and
// scoreboard queues of expected indices and mixed samples.
module tb_osc_phase_sequencer;
  localparam int NV = 4;

  logic clock;
  logic reset;
  logic lut_force;
  int   tests_run;
  int   tests_failed;

  logic [15:0] exp_q[$];
  logic [15:0] exp_idx_q[$];

  logic [31:0] m_phase [NV];
  logic [31:0] m_incr  [NV];
  logic [1:0]  m_wave  [NV];
  logic        m_en    [NV];

  osc_phase_sequencer_if #(.VOICE_W(2), .PHASE_W(32)) bus ();

  osc_phase_sequencer #(.NUM_VOICES(NV), .VOICE_W(2), .PHASE_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in LUTs; the silent slot returns junk that must never be summed.
  function automatic logic [15:0] lut_model(input logic [15:0] idx, input logic [1:0] w);
    case (w)
      2'd0:    lut_model = idx[15] ? 16'h8001 : 16'h7FFF;
      2'd1:    lut_model = (idx == 16'h8000) ? 16'h0000 : idx;
      2'd2:    lut_model = {idx[15], idx[15:1]};
      default: lut_model = 16'h1234;
    endcase
  endfunction

  assign bus.lut_value = lut_force ? 16'h1234 : lut_model(bus.lut_index, bus.lut_wave);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0; m_incr[v] = '0; m_wave[v] = '0; m_en[v] = 1'b0;
    end
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic model_tick();
    int sum;
    logic signed [15:0] t;
    logic [15:0] idx;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      idx = m_phase[v][31:16];
      exp_idx_q.push_back(idx);
      if (m_en[v] && (m_wave[v] != 2'd3)) begin
        t = lut_model(idx, m_wave[v]);
        sum += int'(t);
      end
      if (m_en[v]) m_phase[v] = m_phase[v] + m_incr[v];
    end
    if (sum > 32767)       exp_q.push_back(16'h7FFF);
    else if (sum < -32767) exp_q.push_back(16'h8001);
    else                   exp_q.push_back(16'(sum));
  endtask

  task automatic pop_exp(output logic [15:0] e_samp, output logic [63:0] e_idx);
    e_samp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    for (int v = 0; v < NV; v++)
      e_idx[v*16 +: 16] = (exp_idx_q.size() > 0) ? exp_idx_q.pop_front() : 16'hxxxx;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_voice = '0;
    bus.cfg_incr = '0; bus.cfg_wave = '0; bus.cfg_en = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [31:0] incr,
                           input logic [1:0] w, input logic en);
    bus.cfg_we = 1'b1; bus.cfg_voice = v; bus.cfg_incr = incr;
    bus.cfg_wave = w; bus.cfg_en = en;
    @(posedge clock);
    #1 bus.cfg_we = 1'b0;
    if (en && !m_en[v]) m_phase[v] = '0;
    m_incr[v] = incr; m_wave[v] = w; m_en[v] = en;
  endtask

  // One tick at edge T, then observe cycles after edges T..T+NV+3.
  // cfg_slot >= 0 places a config write on the edge issuing that voice.
  task automatic run_sweep(input int cfg_slot, input logic [1:0] cv, input logic [31:0] ci,
                           input logic [1:0] cw, input logic ce,
                           output logic [63:0] idx_o, output logic [15:0] samp,
                           output int valid_at, output int valid_cnt, output int busy_err);
    idx_o = '0; samp = '0; valid_at = -1; valid_cnt = 0; busy_err = 0;
    bus.sample_tick = 1'b1;
    @(posedge clock);
    #1 bus.sample_tick = 1'b0;
    for (int k = 0; k <= NV + 3; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      if ((cfg_slot >= 0) && (k == cfg_slot + 1)) bus.cfg_we = 1'b0;
      if (k == cfg_slot) begin
        bus.cfg_we = 1'b1; bus.cfg_voice = cv; bus.cfg_incr = ci;
        bus.cfg_wave = cw; bus.cfg_en = ce;
      end
      if ((k >= 1) && (k <= NV)) idx_o[(k-1)*16 +: 16] = bus.lut_index;
      if (bus.busy !== (k <= NV)) busy_err++;
      if (bus.sample_valid === 1'b1) begin
        valid_cnt++; valid_at = k; samp = bus.sample_out;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run += 7;
    if (bus.lut_index !== 16'h0) begin tests_failed++; $display("FAIL reset lut_index: got %h expected 0000", bus.lut_index); end
    if (bus.lut_wave !== 2'd0) begin tests_failed++; $display("FAIL reset lut_wave: got %0d expected 0", bus.lut_wave); end
    if (bus.sample_out !== 16'h0) begin tests_failed++; $display("FAIL reset sample_out: got %h expected 0000", bus.sample_out); end
    if (bus.sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset sample_valid: got %b expected 0", bus.sample_valid); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset overrun: got %b expected 0", bus.overrun); end
    if (bus.dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset state: got %0d expected 0", bus.dbg_state); end
  endtask

  task automatic test_all_disabled();
    logic [63:0] idx, e_idx; logic [15:0] samp, e_samp; int vat, vcnt, berr;
    do_reset();
    lut_force = 1'b1;
    model_tick();
    run_sweep(-1, 2'd0, 32'd0, 2'd0, 1'b0, idx, samp, vat, vcnt, berr);
    lut_force = 1'b0;
    pop_exp(e_samp, e_idx);
    tests_run += 6;
    if (vat !== NV + 1) begin tests_failed++; $display("FAIL disabled latency: got %0d expected %0d", vat, NV + 1); end
    if (vcnt !== 1) begin tests_failed++; $display("FAIL disabled valid count: got %0d expected 1", vcnt); end
    if (samp !== e_samp) begin tests_failed++; $display("FAIL disabled sample: got %h expected %h", samp, e_samp); end
    if (idx !== e_idx) begin tests_failed++; $display("FAIL disabled indices: got %h expected %h", idx, e_idx); end
    if (berr !== 0) begin tests_failed++; $display("FAIL disabled busy window: got %0d bad cycles expected 0", berr); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL disabled overrun: got %b expected 0", bus.overrun); end
  endtask

  // Shared by saw-step and phase-wrap: voice0 saw with the given increment.
  task automatic test_saw_sweeps(input string name, input logic [31:0] incr);
    logic [63:0] idx, e_idx; logic [15:0] samp, e_samp; int vat, vcnt, berr;
    do_reset();
    cfg_write(2'd0, incr, 2'd1, 1'b1);
    for (int t = 0; t < 3; t++) begin
      model_tick();
      run_sweep(-1, 2'd0, 32'd0, 2'd0, 1'b0, idx, samp, vat, vcnt, berr);
      pop_exp(e_samp, e_idx);
      tests_run += 4;
      if (vat !== NV + 1 || vcnt !== 1) begin tests_failed++; $display("FAIL %s valid t%0d: got at %0d x%0d expected at %0d x1", name, t, vat, vcnt, NV + 1); end
      if (samp !== e_samp) begin tests_failed++; $display("FAIL %s sample t%0d: got %h expected %h", name, t, samp, e_samp); end
      if (idx !== e_idx) begin tests_failed++; $display("FAIL %s indices t%0d: got %h expected %h", name, t, idx, e_idx); end
      if (berr !== 0) begin tests_failed++; $display("FAIL %s busy t%0d: got %0d bad cycles expected 0", name, t, berr); end
    end
    tests_run++;
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL %s overrun: got %b expected 0", name, bus.overrun); end
  endtask

  task automatic test_square_saturation();
    logic [63:0] idx, e_idx; logic [15:0] samp, e_samp; int vat, vcnt, berr;
    do_reset();
    for (int v = 0; v < NV; v++) cfg_write(2'(v), 32'h8000_0000, 2'd0, 1'b1);
    for (int t = 0; t < 2; t++) begin
      model_tick();
      run_sweep(-1, 2'd0, 32'd0, 2'd0, 1'b0, idx, samp, vat, vcnt, berr);
      pop_exp(e_samp, e_idx);
      tests_run += 3;
      if (vat !== NV + 1 || vcnt !== 1) begin tests_failed++; $display("FAIL square valid t%0d: got at %0d x%0d expected at %0d x1", t, vat, vcnt, NV + 1); end
      if (samp !== e_samp) begin tests_failed++; $display("FAIL square sample t%0d: got %h expected %h", t, samp, e_samp); end
      if (idx !== e_idx) begin tests_failed++; $display("FAIL square indices t%0d: got %h expected %h", t, idx, e_idx); end
    end
  endtask

  task automatic test_overrun();
    logic [63:0] e_idx; logic [15:0] samp, e_samp; int vcnt;
    do_reset();
    cfg_write(2'd1, 32'h0200_0000, 2'd1, 1'b1);
    model_tick();
    model_tick();
    void'(exp_q.pop_front());
    for (int v = 0; v < NV; v++) void'(exp_idx_q.pop_front());
    // Second sweep is the one observed; the overlapping tick must be dropped.
    bus.sample_tick = 1'b1; @(posedge clock); #1 bus.sample_tick = 1'b0;
    repeat (NV + 3) @(posedge clock);
    #1;
    vcnt = 0; samp = '0;
    bus.sample_tick = 1'b1; @(posedge clock); #1 bus.sample_tick = 1'b0;
    @(posedge clock); #1 bus.sample_tick = 1'b1;
    @(posedge clock); #1 bus.sample_tick = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (bus.sample_valid === 1'b1) begin vcnt++; samp = bus.sample_out; end
    end
    pop_exp(e_samp, e_idx);
    tests_run += 4;
    if (vcnt !== 1) begin tests_failed++; $display("FAIL overrun valid count: got %0d expected 1", vcnt); end
    if (samp !== e_samp) begin tests_failed++; $display("FAIL overrun sample: got %h expected %h", samp, e_samp); end
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun flag: got %b expected 1", bus.overrun); end
    repeat (5) @(posedge clock);
    #1;
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun sticky: got %b expected 1", bus.overrun); end
    do_reset();
    tests_run++;
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun cleared: got %b expected 0", bus.overrun); end
  endtask

  task automatic test_reset_mid_sweep();
    logic [63:0] idx, e_idx; logic [15:0] samp, e_samp; int vat, vcnt, berr;
    do_reset();
    cfg_write(2'd3, 32'h1000_0000, 2'd1, 1'b1);
    for (int t = 0; t < 2; t++) begin
      model_tick();
      run_sweep(-1, 2'd0, 32'd0, 2'd0, 1'b0, idx, samp, vat, vcnt, berr);
      pop_exp(e_samp, e_idx);
      tests_run++;
      if (samp !== e_samp) begin tests_failed++; $display("FAIL abort pre-sample t%0d: got %h expected %h", t, samp, e_samp); end
    end
    bus.sample_tick = 1'b1; @(posedge clock); #1 bus.sample_tick = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    tests_run += 6;
    if (bus.lut_index !== 16'h0) begin tests_failed++; $display("FAIL abort lut_index: got %h expected 0000", bus.lut_index); end
    if (bus.lut_wave !== 2'd0) begin tests_failed++; $display("FAIL abort lut_wave: got %0d expected 0", bus.lut_wave); end
    if (bus.sample_out !== 16'h0) begin tests_failed++; $display("FAIL abort sample_out: got %h expected 0000", bus.sample_out); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort busy: got %b expected 0", bus.busy); end
    if (bus.dbg_state !== 2'd0) begin tests_failed++; $display("FAIL abort state: got %0d expected 0", bus.dbg_state); end
    if (bus.sample_valid !== 1'b0) begin tests_failed++; $display("FAIL abort valid at reset: got %b expected 0", bus.sample_valid); end
    reset = 1'b0;
    model_reset();
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (bus.sample_valid === 1'b1) vcnt++;
    end
    tests_run++;
    if (vcnt !== 0) begin tests_failed++; $display("FAIL abort stray valid: got %0d expected 0", vcnt); end
  endtask

  task automatic test_enable_collision();
    logic [63:0] idx, e_idx; logic [15:0] samp, e_samp; int vat, vcnt, berr;
    do_reset();
    cfg_write(2'd2, 32'h4000_0000, 2'd1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      if (t == 1) cfg_write(2'd2, 32'h4000_0000, 2'd1, 1'b0);
      model_tick();
      if (t == 1) begin
        // Enable lands on voice2's own issue edge: phase restarts at 0.
        run_sweep(2, 2'd2, 32'h4000_0000, 2'd1, 1'b1, idx, samp, vat, vcnt, berr);
        m_en[2] = 1'b1; m_phase[2] = '0;
      end else begin
        run_sweep(-1, 2'd0, 32'd0, 2'd0, 1'b0, idx, samp, vat, vcnt, berr);
      end
      pop_exp(e_samp, e_idx);
      tests_run += 3;
      if (vat !== NV + 1 || vcnt !== 1) begin tests_failed++; $display("FAIL collision valid t%0d: got at %0d x%0d expected at %0d x1", t, vat, vcnt, NV + 1); end
      if (samp !== e_samp) begin tests_failed++; $display("FAIL collision sample t%0d: got %h expected %h", t, samp, e_samp); end
      if (idx !== e_idx) begin tests_failed++; $display("FAIL collision indices t%0d: got %h expected %h", t, idx, e_idx); end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    lut_force = 1'b0;
    reset = 1'b1;
    bus.sample_tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_voice = '0;
    bus.cfg_incr = '0; bus.cfg_wave = '0; bus.cfg_en = 1'b0;
    test_reset();
    test_all_disabled();
    test_saw_sweeps("saw_step", 32'h0100_0000);
    test_saw_sweeps("phase_wrap", 32'h8000_0000);
    test_square_saturation();
    test_overrun();
    test_reset_mid_sweep();
    test_enable_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
